feedback_loop_unit: RTL and testbench
=====================================

Name: feedback_loop_unit

Overview:
- Parametrised successor to the single-bit NAND feedback cell.
- Each cycle, combines a WIDTH-bit input with the tail of a DEPTH-stage register delay line using a runtime-selectable operator, and feeds the result back into the head of the line.
- Adds clock enable, parallel load, and a stability detector.
- Used as a building block for Cava arrow examples: toggle cells, LFSR-like loops, accumulators.

Parameters:
- WIDTH, 1, datapath width in bits (≥1).
- DEPTH, 1, number of registers in the feedback loop (≥1).
- RESET_VALUE, 0, value loaded into every stage on reset (WIDTH bits).
- STABLE_CYCLES, 4, consecutive unchanged updates required before `stable` asserts (≥1).

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- en, input, 1, advance loop when high; hold when low.
- mode, input, 3, operator select (see Behaviour).
- load, input, 1, parallel load of all stages.
- load_value, input, WIDTH, value written by load.
- input1, input, WIDTH, data operand.
- output1, output, WIDTH, combinational operator result op(input1, tail).
- tail, output, WIDTH, registered value of stage[DEPTH-1].
- stable, output, 1, registered stability flag.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- State: stage[0..DEPTH-1], each WIDTH bits; tail = stage[DEPTH-1].
- Stability counter `cnt` is $clog2(STABLE_CYCLES+1) bits, saturating.
- output1 is combinational from input1, mode and tail:
  - Zero latency; a mode change affects output1 in the same cycle.
  - Bitwise ops are per bit.
- mode encoding:
  - 0 NAND, 1 AND, 2 OR, 3 NOR, 4 XOR, 5 XNOR.
  - 6 ADD: (input1 + tail) mod 2^WIDTH; carry discarded, wraps silently.
  - 7 PASS: output1 = input1, tail ignored.
- Priority per rising edge: rst > load > en.
  - rst=1: all stages <= RESET_VALUE; cnt <= 0; stable <= 0. Applies mid-operation and regardless of load/en.
  - load=1 (rst=0): all stages <= load_value; cnt <= 0; stable <= 0. Applies even if en=0.
  - en=1 (rst=0, load=0):
    - stage[0] <= output1; stage[i] <= stage[i-1] for i ≥ 1.
    - cnt <= (output1 == stage[0]) ? min(cnt+1, STABLE_CYCLES) : 0.
  - en=0: all state, cnt and stable hold. output1 still follows input1/mode combinationally.
- stable is registered: stable <= (next cnt == STABLE_CYCLES).
  - Deasserts on the edge where a differing value enters stage[0].
- Values after reset release: tail = RESET_VALUE; output1 = op(input1, RESET_VALUE); stable = 0.
- DEPTH=1: stage[0] is also tail, giving exactly the single-register NAND cell when WIDTH=1 and mode=0.
- Loop latency: a value written into stage[0] appears on tail DEPTH enabled edges later.
- No combinational path from en, load or load_value to output1.
- X on input1 while en=0 must not corrupt state.

Test Plan:
- NAND toggle, WIDTH=1, DEPTH=1, mode=0, en=1.
  - Stimulus: reset for one cycle, then input1 = 0,0,1,1,1,1,0,0 on successive cycles.
  - Required: output1 = 1,1,0,1,0,1,1,1; tail = 0,1,1,0,1,0,1,1.
- Accumulator wrap, WIDTH=8, DEPTH=1, mode=6, RESET_VALUE=0, input1=0x40 constant, en=1.
  - Required: output1 = 0x40,0x80,0xC0,0x00,0x40.
  - Required: tail lags output1 by one cycle.
- Deep loop, WIDTH=1, DEPTH=3, mode=4 (XOR), input1=1, en=1 from reset.
  - Required: output1 = 1,1,1,0,0,0,1,1,1 (period 6).
- Enable/load priority, WIDTH=8, DEPTH=2, mode=6, input1=1.
  - en=0 for 3 cycles: tail unchanged.
  - load=1 with en=0 and load_value=0xA5: both stages = 0xA5 next edge.
  - rst=1 and load=1 together: stages = RESET_VALUE.
- Stability, WIDTH=1, DEPTH=1, STABLE_CYCLES=4, mode=2 (OR), input1=1, en=1 from reset.
  - Required: stable=1 after the 5th enabled edge.
  - Then switch to mode=0 (NAND): stable=0 on the next edge.
  - Then en=0: stable holds 0.
- Reset mid-operation, any mode, DEPTH=4, WIDTH=4.
  - Stimulus: pulse rst while en=1 and state is non-zero.
  - Required: all stages = RESET_VALUE, stable=0 on that edge; normal stepping resumes on the next edge.

Source files
------------

// File: rtl/feedback_loop_unit.sv
// rtl/feedback_loop_unit.sv - WIDTH-bit operator feeding a DEPTH-stage delay line, with stability detect
// Successor to the single-bit NAND feedback cell; DEPTH=1, WIDTH=1, mode=0 reproduces it exactly.
module feedback_loop_unit #(
    parameter int               WIDTH         = 1,
    parameter int               DEPTH         = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE   = '0,
    parameter int               STABLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [WIDTH-1:0] input1,
    output logic [WIDTH-1:0] output1,
    output logic [WIDTH-1:0] tail,
    output logic             stable
);

    localparam int            CW  = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] SAT = CW'(STABLE_CYCLES);

    logic [WIDTH-1:0] r_stage [DEPTH];
    logic [CW-1:0]    r_cnt;
    logic             r_stable;
    logic [CW-1:0]    w_cnt_next;
    logic [WIDTH-1:0] w_op;

    always_comb begin
        w_op = input1;
        case (mode)
            3'd0: w_op = ~(input1 & tail);
            3'd1: w_op = input1 & tail;
            3'd2: w_op = input1 | tail;
            3'd3: w_op = ~(input1 | tail);
            3'd4: w_op = input1 ^ tail;
            3'd5: w_op = ~(input1 ^ tail);
            3'd6: w_op = input1 + tail;
            default: w_op = input1;
        endcase
    end

    // Counts enabled updates that rewrite stage[0] with its current value, saturating.
    always_comb begin
        w_cnt_next = '0;
        if (w_op == r_stage[0]) begin
            w_cnt_next = (r_cnt == SAT) ? r_cnt : r_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_stage[i] <= RESET_VALUE;
            r_cnt    <= '0;
            r_stable <= 1'b0;
        end else if (load) begin
            for (int i = 0; i < DEPTH; i++) r_stage[i] <= load_value;
            r_cnt    <= '0;
            r_stable <= 1'b0;
        end else if (en) begin
            r_stage[0] <= w_op;
            for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
            r_cnt    <= w_cnt_next;
            r_stable <= (w_cnt_next == SAT);
        end
    end

    assign output1 = w_op;
    assign tail    = r_stage[DEPTH-1];
    assign stable  = r_stable;

endmodule

// File: tb/tb_feedback_loop_unit.sv
// tb/tb_feedback_loop_unit.sv - table-driven bench over five parameterisations of feedback_loop_unit
module tb_feedback_loop_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         dut;
        logic       rst;
        logic       en;
        logic       load;
        logic [2:0] mode;
        logic [7:0] in;
        logic [7:0] lv;
        logic       chk_out;
        logic [7:0] exp_out;
        logic [7:0] exp_tail;
        logic       exp_stable;
    } vec_t;

    vec_t vecs[$];
    int errors = 0;
    int checks = 0;

    // A: W1 D1  B: W8 D1  C: W1 D3  D: W8 D2 RV=3C  E: W4 D4 RV=9
    logic       a_rst = 0, a_en = 0, a_load = 0; logic [2:0] a_mode = 0;
    logic       a_in = 0, a_lv = 0, a_out, a_tail, a_stable;
    logic       b_rst = 0, b_en = 0, b_load = 0; logic [2:0] b_mode = 0;
    logic [7:0] b_in = 0, b_lv = 0, b_out, b_tail; logic b_stable;
    logic       c_rst = 0, c_en = 0, c_load = 0; logic [2:0] c_mode = 0;
    logic       c_in = 0, c_lv = 0, c_out, c_tail, c_stable;
    logic       d_rst = 0, d_en = 0, d_load = 0; logic [2:0] d_mode = 0;
    logic [7:0] d_in = 0, d_lv = 0, d_out, d_tail; logic d_stable;
    logic       e_rst = 0, e_en = 0, e_load = 0; logic [2:0] e_mode = 0;
    logic [3:0] e_in = 0, e_lv = 0, e_out, e_tail; logic e_stable;

    feedback_loop_unit #(.WIDTH(1), .DEPTH(1), .RESET_VALUE(1'b0), .STABLE_CYCLES(4)) u_a (
        .clk(clk), .rst(a_rst), .en(a_en), .mode(a_mode), .load(a_load), .load_value(a_lv),
        .input1(a_in), .output1(a_out), .tail(a_tail), .stable(a_stable));
    feedback_loop_unit #(.WIDTH(8), .DEPTH(1), .RESET_VALUE(8'h00), .STABLE_CYCLES(4)) u_b (
        .clk(clk), .rst(b_rst), .en(b_en), .mode(b_mode), .load(b_load), .load_value(b_lv),
        .input1(b_in), .output1(b_out), .tail(b_tail), .stable(b_stable));
    feedback_loop_unit #(.WIDTH(1), .DEPTH(3), .RESET_VALUE(1'b0), .STABLE_CYCLES(4)) u_c (
        .clk(clk), .rst(c_rst), .en(c_en), .mode(c_mode), .load(c_load), .load_value(c_lv),
        .input1(c_in), .output1(c_out), .tail(c_tail), .stable(c_stable));
    feedback_loop_unit #(.WIDTH(8), .DEPTH(2), .RESET_VALUE(8'h3C), .STABLE_CYCLES(4)) u_d (
        .clk(clk), .rst(d_rst), .en(d_en), .mode(d_mode), .load(d_load), .load_value(d_lv),
        .input1(d_in), .output1(d_out), .tail(d_tail), .stable(d_stable));
    feedback_loop_unit #(.WIDTH(4), .DEPTH(4), .RESET_VALUE(4'h9), .STABLE_CYCLES(4)) u_e (
        .clk(clk), .rst(e_rst), .en(e_en), .mode(e_mode), .load(e_load), .load_value(e_lv),
        .input1(e_in), .output1(e_out), .tail(e_tail), .stable(e_stable));

    function automatic vec_t mk(input int dut, input logic rst, input logic en, input logic load,
                                input logic [2:0] mode, input logic [7:0] in, input logic [7:0] lv,
                                input logic chk_out, input logic [7:0] eo, input logic [7:0] et,
                                input logic es);
        vec_t v;
        v.dut = dut; v.rst = rst; v.en = en; v.load = load; v.mode = mode; v.in = in; v.lv = lv;
        v.chk_out = chk_out; v.exp_out = eo; v.exp_tail = et; v.exp_stable = es;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        case (v.dut)
            0: begin a_rst = v.rst; a_en = v.en; a_load = v.load; a_mode = v.mode; a_in = v.in[0]; a_lv = v.lv[0]; end
            1: begin b_rst = v.rst; b_en = v.en; b_load = v.load; b_mode = v.mode; b_in = v.in; b_lv = v.lv; end
            2: begin c_rst = v.rst; c_en = v.en; c_load = v.load; c_mode = v.mode; c_in = v.in[0]; c_lv = v.lv[0]; end
            3: begin d_rst = v.rst; d_en = v.en; d_load = v.load; d_mode = v.mode; d_in = v.in; d_lv = v.lv; end
            default: begin e_rst = v.rst; e_en = v.en; e_load = v.load; e_mode = v.mode; e_in = v.in[3:0]; e_lv = v.lv[3:0]; end
        endcase
    endtask

    task automatic quiesce(input int dut);
        case (dut)
            0: begin a_rst = 0; a_en = 0; a_load = 0; end
            1: begin b_rst = 0; b_en = 0; b_load = 0; end
            2: begin c_rst = 0; c_en = 0; c_load = 0; end
            3: begin d_rst = 0; d_en = 0; d_load = 0; end
            default: begin e_rst = 0; e_en = 0; e_load = 0; end
        endcase
    endtask

    function automatic logic [7:0] cur_out(input int dut);
        case (dut)
            0: return {7'b0, a_out};
            1: return b_out;
            2: return {7'b0, c_out};
            3: return d_out;
            default: return {4'b0, e_out};
        endcase
    endfunction

    function automatic logic [7:0] cur_tail(input int dut);
        case (dut)
            0: return {7'b0, a_tail};
            1: return b_tail;
            2: return {7'b0, c_tail};
            3: return d_tail;
            default: return {4'b0, e_tail};
        endcase
    endfunction

    function automatic logic cur_stable(input int dut);
        case (dut)
            0: return a_stable;
            1: return b_stable;
            2: return c_stable;
            3: return d_stable;
            default: return e_stable;
        endcase
    endfunction

    task automatic check8(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec=%0d got=%h want=%h", name, idx, act, exp);
        end
    endtask

    initial begin
        // A: reset, NAND toggle
        vecs.push_back(mk(0, 1, 0, 0, 0, 8'h0, 8'h0, 0, 8'h0, 8'h0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 8'h0, 8'h0, 1, 8'h1, 8'h1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 8'h0, 8'h0, 1, 8'h1, 8'h1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 8'h1, 8'h0, 1, 8'h0, 8'h0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 8'h1, 8'h0, 1, 8'h1, 8'h1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 8'h1, 8'h0, 1, 8'h0, 8'h0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 8'h1, 8'h0, 1, 8'h1, 8'h1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 8'h0, 8'h0, 1, 8'h1, 8'h1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 8'h0, 8'h0, 1, 8'h1, 8'h1, 0));
        // A: stability with OR, then NAND breaks it, then hold
        vecs.push_back(mk(0, 1, 0, 0, 2, 8'h1, 8'h0, 0, 8'h0, 8'h0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 2, 8'h1, 8'h0, 1, 8'h1, 8'h1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 2, 8'h1, 8'h0, 1, 8'h1, 8'h1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 2, 8'h1, 8'h0, 1, 8'h1, 8'h1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 2, 8'h1, 8'h0, 1, 8'h1, 8'h1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 2, 8'h1, 8'h0, 1, 8'h1, 8'h1, 1));
        vecs.push_back(mk(0, 0, 1, 0, 2, 8'h1, 8'h0, 1, 8'h1, 8'h1, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 8'h1, 8'h0, 1, 8'h0, 8'h0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 8'h1, 8'h0, 1, 8'h1, 8'h0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 8'h1, 8'h0, 1, 8'h1, 8'h0, 0));
        // B: accumulator wrap
        vecs.push_back(mk(1, 1, 0, 0, 6, 8'h40, 8'h0, 0, 8'h00, 8'h00, 0));
        vecs.push_back(mk(1, 0, 1, 0, 6, 8'h40, 8'h0, 1, 8'h40, 8'h40, 0));
        vecs.push_back(mk(1, 0, 1, 0, 6, 8'h40, 8'h0, 1, 8'h80, 8'h80, 0));
        vecs.push_back(mk(1, 0, 1, 0, 6, 8'h40, 8'h0, 1, 8'hC0, 8'hC0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 6, 8'h40, 8'h0, 1, 8'h00, 8'h00, 0));
        vecs.push_back(mk(1, 0, 1, 0, 6, 8'h40, 8'h0, 1, 8'h40, 8'h40, 0));
        // B: every operator against tail=40, held with en=0
        vecs.push_back(mk(1, 0, 0, 0, 0, 8'hC3, 8'h0, 1, 8'hBF, 8'h40, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 8'hC3, 8'h0, 1, 8'h40, 8'h40, 0));
        vecs.push_back(mk(1, 0, 0, 0, 2, 8'hC3, 8'h0, 1, 8'hC3, 8'h40, 0));
        vecs.push_back(mk(1, 0, 0, 0, 3, 8'hC3, 8'h0, 1, 8'h3C, 8'h40, 0));
        vecs.push_back(mk(1, 0, 0, 0, 4, 8'hC3, 8'h0, 1, 8'h83, 8'h40, 0));
        vecs.push_back(mk(1, 0, 0, 0, 5, 8'hC3, 8'h0, 1, 8'h7C, 8'h40, 0));
        vecs.push_back(mk(1, 0, 0, 0, 6, 8'hC3, 8'h0, 1, 8'h03, 8'h40, 0));
        vecs.push_back(mk(1, 0, 0, 0, 7, 8'hC3, 8'h0, 1, 8'hC3, 8'h40, 0));
        // C: XOR loop through three stages, period 6
        vecs.push_back(mk(2, 1, 0, 0, 4, 8'h1, 8'h0, 0, 8'h0, 8'h0, 0));
        vecs.push_back(mk(2, 0, 1, 0, 4, 8'h1, 8'h0, 1, 8'h1, 8'h0, 0));
        vecs.push_back(mk(2, 0, 1, 0, 4, 8'h1, 8'h0, 1, 8'h1, 8'h0, 0));
        vecs.push_back(mk(2, 0, 1, 0, 4, 8'h1, 8'h0, 1, 8'h1, 8'h1, 0));
        vecs.push_back(mk(2, 0, 1, 0, 4, 8'h1, 8'h0, 1, 8'h0, 8'h1, 0));
        vecs.push_back(mk(2, 0, 1, 0, 4, 8'h1, 8'h0, 1, 8'h0, 8'h1, 0));
        vecs.push_back(mk(2, 0, 1, 0, 4, 8'h1, 8'h0, 1, 8'h0, 8'h0, 0));
        vecs.push_back(mk(2, 0, 1, 0, 4, 8'h1, 8'h0, 1, 8'h1, 8'h0, 0));
        vecs.push_back(mk(2, 0, 1, 0, 4, 8'h1, 8'h0, 1, 8'h1, 8'h0, 0));
        vecs.push_back(mk(2, 0, 1, 0, 4, 8'h1, 8'h0, 1, 8'h1, 8'h1, 0));
        // D: enable hold, load with en=0, rst beats load
        vecs.push_back(mk(3, 1, 0, 0, 6, 8'h01, 8'h00, 0, 8'h00, 8'h3C, 0));
        vecs.push_back(mk(3, 0, 1, 0, 6, 8'h01, 8'h00, 1, 8'h3D, 8'h3C, 0));
        vecs.push_back(mk(3, 0, 1, 0, 6, 8'h01, 8'h00, 1, 8'h3D, 8'h3D, 0));
        vecs.push_back(mk(3, 0, 0, 0, 6, 8'h01, 8'h00, 1, 8'h3E, 8'h3D, 0));
        vecs.push_back(mk(3, 0, 0, 0, 6, 8'h01, 8'h00, 1, 8'h3E, 8'h3D, 0));
        vecs.push_back(mk(3, 0, 0, 0, 6, 8'h01, 8'h00, 1, 8'h3E, 8'h3D, 0));
        vecs.push_back(mk(3, 0, 0, 1, 6, 8'h01, 8'hA5, 1, 8'h3E, 8'hA5, 0));
        vecs.push_back(mk(3, 0, 1, 0, 6, 8'h01, 8'h00, 1, 8'hA6, 8'hA5, 0));
        vecs.push_back(mk(3, 0, 1, 0, 6, 8'h01, 8'h00, 1, 8'hA6, 8'hA6, 0));
        vecs.push_back(mk(3, 1, 1, 1, 6, 8'h01, 8'h77, 1, 8'hA7, 8'h3C, 0));
        vecs.push_back(mk(3, 0, 1, 0, 6, 8'h01, 8'h00, 1, 8'h3D, 8'h3C, 0));
        // E: reset mid-operation, then latency of four
        vecs.push_back(mk(4, 1, 0, 0, 4, 8'h0, 8'h0, 0, 8'h0, 8'h9, 0));
        vecs.push_back(mk(4, 0, 1, 0, 4, 8'h5, 8'h0, 1, 8'hC, 8'h9, 0));
        vecs.push_back(mk(4, 0, 1, 0, 4, 8'h3, 8'h0, 1, 8'hA, 8'h9, 0));
        vecs.push_back(mk(4, 0, 1, 0, 4, 8'h6, 8'h0, 1, 8'hF, 8'h9, 0));
        vecs.push_back(mk(4, 0, 1, 0, 4, 8'h0, 8'h0, 1, 8'h9, 8'hC, 0));
        vecs.push_back(mk(4, 0, 1, 0, 4, 8'h0, 8'h0, 1, 8'hC, 8'hA, 0));
        vecs.push_back(mk(4, 1, 1, 0, 4, 8'h7, 8'h0, 1, 8'hD, 8'h9, 0));
        vecs.push_back(mk(4, 0, 1, 0, 4, 8'h2, 8'h0, 1, 8'hB, 8'h9, 0));
        vecs.push_back(mk(4, 0, 1, 0, 4, 8'h0, 8'h0, 1, 8'h9, 8'h9, 0));
        vecs.push_back(mk(4, 0, 1, 0, 4, 8'h0, 8'h0, 1, 8'h9, 8'h9, 0));
        vecs.push_back(mk(4, 0, 1, 0, 4, 8'h0, 8'h0, 1, 8'h9, 8'hB, 0));

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            if (vecs[i].chk_out) check8("output1", i, cur_out(vecs[i].dut), vecs[i].exp_out);
            @(posedge clk);
            #1;
            check8("tail", i, cur_tail(vecs[i].dut), vecs[i].exp_tail);
            check8("stable", i, {7'b0, cur_stable(vecs[i].dut)}, {7'b0, vecs[i].exp_stable});
            quiesce(vecs[i].dut);
        end

        // Zero-latency mode switch on D while held (tail=3C, stages 3D/3C)
        @(negedge clk);
        d_en = 0; d_in = 8'h55; d_mode = 3'd7;
        #1 check8("pass_now", 0, d_out, 8'h55);
        d_mode = 3'd0;
        #1 check8("nand_now", 0, d_out, 8'hEB);
        d_load = 0; d_lv = 8'hFF;
        #1 check8("no_lv_path", 0, d_out, 8'hEB);
        @(posedge clk);
        #1 check8("held_tail", 0, d_tail, 8'h3C);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
